// File: rtl/key_calculation.sv
// Kuznyechik key schedule: loads a 256-bit master key and runs 32 Feistel rounds, one per clock,
// capturing round keys K3..K10 every eighth round; finish marks the full set valid.
module key_calculation (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [255:0] key,
    output logic [127:0] key_1,
    output logic [127:0] key_2,
    output logic [127:0] key_3,
    output logic [127:0] key_4,
    output logic [127:0] key_5,
    output logic [127:0] key_6,
    output logic [127:0] key_7,
    output logic [127:0] key_8,
    output logic [127:0] key_9,
    output logic [127:0] key_10,
    output logic [127:0] reg_left,
    output logic [127:0] reg_right,
    output logic         finish
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Byte k of LCOEF multiplies byte a_k; the top byte belongs to a15.
    localparam logic [127:0] LCOEF = {8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] s_fn(input logic [127:0] a);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = PI[a[8*k +: 8]];
        return v;
    endfunction

    function automatic logic [127:0] l_fn(input logic [127:0] a);
        logic [127:0] v;
        logic [7:0]   l;
        v = a;
        for (int r = 0; r < 16; r++) begin
            l = 8'h00;
            for (int k = 0; k < 16; k++) l = l ^ gf_mul(LCOEF[8*k +: 8], v[8*k +: 8]);
            v = {l, v[127:8]};
        end
        return v;
    endfunction

    // Round constants C_1..C_32; arguments are constant so these fold into a ROM.
    logic [127:0] c_rom [32];
    for (genvar g = 0; g < 32; g++) begin : g_crom
        assign c_rom[g] = l_fn(128'(g + 1));
    end

    state_t       state, next_state;
    logic [4:0]   round;
    logic [127:0] rk [10];
    logic         load, step;
    logic [127:0] new_left;
    logic [3:0]   kidx_lo, kidx_hi;

    assign new_left = l_fn(s_fn(reg_left ^ c_rom[round - 5'd1])) ^ reg_right;
    // Round 32 wraps the counter to 0, which maps to the last key pair.
    assign kidx_lo  = {1'b0, round[4:3] - 2'd1, 1'b0} + 4'd2;
    assign kidx_hi  = kidx_lo + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    load       = 1'b1;
                    next_state = RUN;
                end
                RUN: begin
                    step = 1'b1;
                    if (round == 5'd0) next_state = DONE;
                end
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round     <= 5'd0;
            finish    <= 1'b0;
            reg_left  <= '0;
            reg_right <= '0;
            for (int i = 0; i < 10; i++) rk[i] <= '0;
        end else begin
            if (!enable) finish <= 1'b0;
            if (load) begin
                reg_left  <= key[255:128];
                reg_right <= key[127:0];
                rk[0]     <= key[255:128];
                rk[1]     <= key[127:0];
                round     <= 5'd1;
            end
            if (step) begin
                reg_left  <= new_left;
                reg_right <= reg_left;
                round     <= round + 5'd1;
                if (round[2:0] == 3'd0) begin
                    rk[kidx_lo] <= new_left;
                    rk[kidx_hi] <= reg_left;
                end
                if (round == 5'd0) finish <= 1'b1;
            end
        end
    end

    assign key_1  = rk[0];
    assign key_2  = rk[1];
    assign key_3  = rk[2];
    assign key_4  = rk[3];
    assign key_5  = rk[4];
    assign key_6  = rk[5];
    assign key_7  = rk[6];
    assign key_8  = rk[7];
    assign key_9  = rk[8];
    assign key_10 = rk[9];

endmodule

// File: tb/tb_key_calculation.sv
// Scoreboard bench for key_calculation: expected key sets are queued at each load and
// checked by a monitor when finish rises; a byte-level reference model covers random keys.
module tb_key_calculation;

    typedef logic [9:0][127:0] keyset_t;

    localparam logic [255:0] STD_KEY = 256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;
    localparam keyset_t STD_EXP = {
        128'h72e9dd7416bcf45b755dbaa88e4a4043, 128'hbb44e25378c73123a5f32f73cdb6e517,
        128'h5a7925017b9fdd3ed72a91a22286f984, 128'h51e640757e8745de705727265a0098b1,
        128'hbd079435165c6432b532e82834da581b, 128'h57646468c44a5e28d3e59246f429f1ac,
        128'h3d4553d8e9cfec6815ebadc40a9ffd04, 128'hdb31485315694343228d6aef8cc78c44,
        128'hfedcba98765432100123456789abcdef, 128'h8899aabbccddeeff0011223344556677
    };

    localparam logic [7:0] TB_PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };
    // Coefficients listed for a15 down to a0.
    localparam logic [7:0] COEF [16] = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                         8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};

    logic         clk = 1'b0;
    logic         rst, enable;
    logic [255:0] key;
    logic [127:0] key_1, key_2, key_3, key_4, key_5, key_6, key_7, key_8, key_9, key_10;
    logic [127:0] reg_left, reg_right;
    logic         finish;
    logic [127:0] kout [10];

    key_calculation dut (
        .clk(clk), .rst(rst), .enable(enable), .key(key),
        .key_1(key_1), .key_2(key_2), .key_3(key_3), .key_4(key_4), .key_5(key_5),
        .key_6(key_6), .key_7(key_7), .key_8(key_8), .key_9(key_9), .key_10(key_10),
        .reg_left(reg_left), .reg_right(reg_right), .finish(finish)
    );

    assign kout[0] = key_1;  assign kout[1] = key_2;  assign kout[2] = key_3;
    assign kout[3] = key_4;  assign kout[4] = key_5;  assign kout[5] = key_6;
    assign kout[6] = key_7;  assign kout[7] = key_8;  assign kout[8] = key_9;
    assign kout[9] = key_10;

    always #5 clk = ~clk;

    int      cyc = 0;
    int      load_cyc = 0;
    int      n_vec = 0;
    int      n_bad = 0;
    keyset_t sb_q [$];

    always @(posedge clk) cyc++;

    // Carry-less multiply, then reduce modulo x^8+x^7+x^6+x+1.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h1C3 << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] m_L(input logic [127:0] w);
        logic [7:0]   a [16];
        logic [7:0]   l;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) a[k] = w[8*k +: 8];
        for (int r = 0; r < 16; r++) begin
            l = 8'h00;
            for (int k = 0; k < 16; k++) l = l ^ m_mul(COEF[15 - k], a[k]);
            for (int k = 0; k < 15; k++) a[k] = a[k + 1];
            a[15] = l;
        end
        o = '0;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = a[k];
        return o;
    endfunction

    function automatic logic [127:0] m_S(input logic [127:0] w);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = TB_PI[w[8*k +: 8]];
        return o;
    endfunction

    function automatic keyset_t model(input logic [255:0] k);
        keyset_t      r;
        logic [127:0] left, right, t;
        r     = '0;
        left  = k[255:128];
        right = k[127:0];
        r[0]  = left;
        r[1]  = right;
        for (int i = 1; i <= 32; i++) begin
            t     = m_L(m_S(left ^ m_L(128'(i)))) ^ right;
            right = left;
            left  = t;
            if (i % 8 == 0) begin
                r[i / 4]     = left;
                r[i / 4 + 1] = right;
            end
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 10; i++) check($sformatf("%s key_%0d", tag, i + 1), kout[i], '0);
        check({tag, " reg_left"}, reg_left, '0);
        check({tag, " reg_right"}, reg_right, '0);
        check({tag, " finish"}, {127'b0, finish}, '0);
    endtask

    // Monitor: each rising finish consumes one expected key set.
    keyset_t mon_exp;
    logic    fin_d = 1'b0;
    always @(negedge clk) begin
        if (finish && !fin_d) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_finish @cycle %0d: finish rose, expected none", cyc);
            end else begin
                mon_exp = sb_q.pop_front();
                for (int i = 0; i < 10; i++) check($sformatf("sb key_%0d", i + 1), kout[i], mon_exp[i]);
                check("sb reg_left", reg_left, mon_exp[8]);
                check("sb reg_right", reg_right, mon_exp[9]);
                check("sb latency", 128'(cyc - load_cyc + 1), 128'd33);
            end
        end
        fin_d = finish;
    end

    // Called just after a negedge; returns at the negedge after finish rises.
    task automatic run(input logic [255:0] k, input keyset_t exp, input bit timeline);
        int e;
        sb_q.push_back(exp);
        key    = k;
        enable = 1'b1;
        @(posedge clk); #1;
        load_cyc = cyc;
        e = 1;
        check("load key_1", key_1, exp[0]);
        check("load key_2", key_2, exp[1]);
        while (!finish && e < 40) begin
            key = rand256();
            @(posedge clk); #1;
            e++;
            if (timeline) begin
                case (e)
                    8:  check("edge8 key_3", key_3, '0);
                    9:  begin check("edge9 key_3", key_3, exp[2]); check("edge9 key_4", key_4, exp[3]); end
                    16: check("edge16 key_5", key_5, '0);
                    17: begin check("edge17 key_5", key_5, exp[4]); check("edge17 key_6", key_6, exp[5]); end
                    24: check("edge24 key_7", key_7, '0);
                    25: begin check("edge25 key_7", key_7, exp[6]); check("edge25 key_8", key_8, exp[7]); end
                    default: ;
                endcase
            end
        end
        if (!finish) begin
            n_vec++;
            n_bad++;
            $display("FAIL finish_timeout: finish=%0b after %0d edges, expected 1 by edge 33", finish, e);
            void'(sb_q.pop_back());
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        key    = STD_KEY;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        run(STD_KEY, STD_EXP, 1'b1);

        // Held in DONE: nothing may move.
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 10; i++) check($sformatf("hold key_%0d", i + 1), kout[i], STD_EXP[i]);
            check("hold reg_left", reg_left, STD_EXP[8]);
            check("hold reg_right", reg_right, STD_EXP[9]);
            check("hold finish", {127'b0, finish}, 128'd1);
        end

        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check("drop finish", {127'b0, finish}, '0);
        for (int i = 0; i < 10; i++) check($sformatf("drop key_%0d", i + 1), kout[i], STD_EXP[i]);
        @(negedge clk);
        run(STD_KEY, STD_EXP, 1'b0);

        // Abort after edge 12 from a cleared state.
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        key    = STD_KEY;
        enable = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            check("abort finish", {127'b0, finish}, '0);
        end
        for (int i = 0; i < 4; i++) check($sformatf("abort key_%0d", i + 1), kout[i], STD_EXP[i]);
        for (int i = 4; i < 10; i++) check($sformatf("abort key_%0d", i + 1), kout[i], '0);

        // Reset landing on edge 20 of a run, then reload while enable stays high.
        @(negedge clk);
        key    = STD_KEY;
        enable = 1'b1;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst20");
        @(negedge clk);
        rst = 1'b0;
        run(STD_KEY, STD_EXP, 1'b1);

        for (int r = 0; r < 6; r++) begin
            logic [255:0] k;
            @(negedge clk);
            enable = 1'b0;
            key    = rand256();
            repeat ($urandom_range(1, 3)) @(negedge clk);
            k = rand256();
            run(k, model(k), 1'b0);
        end

        @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_drain", 128'(sb_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/key_calculation.md
KEY_CALCULATION -- requirements
Module: key_calculation

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 enable  input  1  start/hold request; high starts expansion, low aborts or returns to idle.
REQ-005 key  input  256  master key; key[255:128]=K1, key[127:0]=K2; sampled only on the load edge.
REQ-006 key_1 .. key_10  output  128 each  registered round keys K1..K10.
REQ-007 reg_left  output  128  current Feistel left half (debug).
REQ-008 reg_right  output  128  current Feistel right half (debug).
REQ-009 finish  output  1  registered; high when all ten keys are valid.

Function
REQ-010 Algorithm: Kuznyechik (GOST R 34.12-2015) key schedule, one Feistel round per clock.
REQ-011 Round i (i=1..32): new_left = L(S(left xor C_i)) xor right; new_right = left.
REQ-012 S: byte-wise standard pi substitution, e.g. pi[0x00]=0xFC, pi[0x01]=0xEE.
REQ-013 Byte a15 is the most significant byte of each 128-bit word.
REQ-014 L: 16 iterations of R, implemented combinationally.
REQ-015 R(a15..a0) = (l, a15..a1), where l = GF(2^8) sum of coef_k*a_k.
REQ-016 Coefficients for a15..a0: 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1.
REQ-017 GF(2^8) field polynomial: x^8+x^7+x^6+x+1.
REQ-018 C_i = L(Vec128(i)); constants come from a 32-entry ROM; C_1 = 6ea276726c487ab85d27bd10dd849401.
REQ-019 States: IDLE, RUN, DONE; 5-bit round counter.
REQ-020 IDLE with enable=1 at an edge (load edge):
  - reg_left<=key[255:128], reg_right<=key[127:0]
  - key_1<=key[255:128], key_2<=key[127:0]
  - round<=1, go to RUN.
REQ-021 RUN with enable=1: each edge applies round `round` to reg_left/reg_right, then increments round.
REQ-022 After round 8j (j=1..4), on the same edge: key_(2j+1)<=new_left, key_(2j+2)<=new_right.
REQ-023 At the edge completing round 32: finish<=1, go to DONE.
REQ-024 finish is first high exactly 33 rising edges after the load edge (load edge counts as 1).
REQ-025 DONE with enable=1: all outputs hold; finish stays high; no restart.
REQ-026 enable=0 in any state: go to IDLE, finish<=0, keys and halves hold their values.
REQ-027 An abort mid-RUN leaves partial keys visible; finish=0 marks them invalid.
REQ-028 A new expansion needs enable to return low, then high; the load edge then reloads everything.
REQ-029 key changes after the load edge are ignored until the next load edge.

Reset
REQ-030 rst=1 at an edge: state IDLE, round 0, finish 0, key_1..key_10 = 0, reg_left = reg_right = 0.
REQ-031 rst has priority over enable.
REQ-032 rst mid-RUN discards the expansion.
REQ-033 After rst deasserts, a load occurs at the next edge where enable=1.

Verification
REQ-034 Standard vector: key = 8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef, enable held high -> finish rises on edge 33, with:
  - K1 = 8899aabbccddeeff0011223344556677, K2 = fedcba98765432100123456789abcdef
  - K3 = db31485315694343228d6aef8cc78c44, K4 = 3d4553d8e9cfec6815ebadc40a9ffd04
  - K5 = 57646468c44a5e28d3e59246f429f1ac, K6 = bd079435165c6432b532e82834da581b
  - K7 = 51e640757e8745de705727265a0098b1, K8 = 5a7925017b9fdd3ed72a91a22286f984
  - K9 = bb44e25378c73123a5f32f73cdb6e517, K10 = 72e9dd7416bcf45b755dbaa88e4a4043.
REQ-035 Same vector -> key_3/key_4 update on edge 9; key_5/key_6 on edge 17; key_7/key_8 on edge 25; key_9/key_10 on edge 33.
REQ-036 After finish, enable held high for 500 further cycles -> all outputs and finish remain stable.
REQ-037 Same vector, enable dropped after edge 12 -> finish stays 0; key_3/key_4 keep their correct values; key_5..key_10 unchanged.
REQ-038 rst pulsed at edge 20 of a run -> all outputs 0 next cycle; re-enable reproduces the REQ-034 values with finish again at edge 33.
REQ-039 Run the vector, drop enable, then run again -> identical keys and latency.
